vc_input_buffer: RTL and testbench

- Per-input-port virtual-channel buffer that sits directly upstream of the port's 2-requester round-robin arbiter.
- Stores incoming flits in one FIFO per VC and raises `req_o` toward the arbiter.
- Pops the granted VC's head flit and pulses `update_o` only at packet boundaries, so the arbiter rotates priority per packet, not per flit.
- Holds a VC lock from head flit to tail flit, so packets are never interleaved on the output.

---
 rtl/vc_input_buffer.sv | 139 +++++++++++++
 tb/tb_vc_input_buffer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_input_buffer.sv
// Per-port virtual-channel input buffer: one FIFO per VC feeding a 2-requester arbiter,
// with a head-to-tail VC lock. Define VC_BUF_OCC_EN to add the registered occupancy output occ_o.
module vc_input_buffer #(
  parameter int FLIT_WIDTH = 34,
  parameter int BUF_DEPTH  = 4,
  parameter int N_VC       = 2
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [FLIT_WIDTH-1:0] flit_i,
  input  logic                  vc_id_i,
  input  logic                  valid_i,
  output logic [N_VC-1:0]       ready_o,
  output logic [N_VC-1:0]       req_o,
  input  logic [N_VC-1:0]       grant_i,
  output logic                  update_o,
  output logic [FLIT_WIDTH-1:0] flit_o,
  output logic                  valid_o,
  input  logic                  out_ready_i,
  output logic                  grant_err_o
`ifdef VC_BUF_OCC_EN
  ,
  output logic [N_VC*($clog2(BUF_DEPTH)+1)-1:0] occ_o
`endif
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    FT_HEAD      = 2'b00,
    FT_BODY      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  logic [FLIT_WIDTH-1:0] mem [N_VC][BUF_DEPTH];
  logic [PW-1:0]         wr_ptr [N_VC];
  logic [PW-1:0]         rd_ptr [N_VC];
  logic [N_VC-1:0]       empty, full, push, pop_vc, lock_mask, gv;
  logic                  sel, pop, grant_bad, lock_vc, grant_err;
  flit_type_e            out_type;
  state_e                state;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  always_comb begin
    for (int v = 0; v < N_VC; v++) begin
      empty[v] = (wr_ptr[v] == rd_ptr[v]);
      full[v]  = (wr_ptr[v][AW] != rd_ptr[v][AW]) &&
                 (wr_ptr[v][AW-1:0] == rd_ptr[v][AW-1:0]);
      push[v]  = valid_i && (vc_id_i == 1'(v)) && !full[v];
    end
  end

  assign ready_o   = ~full;
  assign lock_mask = N_VC'(1) << lock_vc;
  assign req_o     = (state == LOCKED) ? (~empty & lock_mask) : ~empty;
  assign gv        = grant_i & req_o;
  assign valid_o   = $onehot(gv);
  assign sel       = gv[1];
  assign flit_o    = valid_o ? mem[sel][rd_ptr[sel][AW-1:0]] : '0;
  assign pop       = valid_o && out_ready_i;
  assign pop_vc    = pop ? gv : '0;
  assign out_type  = flit_type_e'(flit_o[FLIT_WIDTH-1 -: 2]);
  assign grant_bad = !$onehot0(grant_i) || ((grant_i & ~req_o) != '0);

  // A HEAD_TAIL seen while locked is a stray packet inside another one, so it must not rotate priority.
  assign update_o  = pop && ((out_type == FT_TAIL) ||
                             ((state == IDLE) && (out_type == FT_HEAD_TAIL)));
  assign grant_err_o = grant_err;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int v = 0; v < N_VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
      end
    end else begin
      for (int v = 0; v < N_VC; v++) begin
        if (push[v])   wr_ptr[v] <= wr_ptr[v] + PW'(1);
        if (pop_vc[v]) rd_ptr[v] <= rd_ptr[v] + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < N_VC; v++) begin
      if (push[v]) mem[v][wr_ptr[v][AW-1:0]] <= flit_i;
    end
  end

  // Out-of-place flit types are forwarded without touching the lock, so a bad source cannot wedge the port.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state     <= IDLE;
      lock_vc   <= 1'b0;
      grant_err <= 1'b0;
    end else begin
      grant_err <= grant_err | grant_bad;
      if (pop) begin
        case (state)
          IDLE: begin
            if (out_type == FT_HEAD) begin
              state   <= LOCKED;
              lock_vc <= sel;
            end
          end
          LOCKED: begin
            if (out_type == FT_TAIL) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef VC_BUF_OCC_EN
  logic [PW-1:0] occ [N_VC];

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      for (int v = 0; v < N_VC; v++) occ[v] <= '0;
    end else begin
      for (int v = 0; v < N_VC; v++) occ[v] <= occ[v] + PW'(push[v]) - PW'(pop_vc[v]);
    end
  end

  always_comb begin
    occ_o = '0;
    for (int v = 0; v < N_VC; v++) occ_o[v*PW +: PW] = occ[v];
  end
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
// Testbench for vc_input_buffer: directed packet scenarios followed by random traffic,
// all checked against a queue-based model of the buffer's packet rules.
module tb_vc_input_buffer;
  localparam int FW    = 34;
  localparam int DEPTH = 4;
  localparam int PW    = 3;
  localparam logic [1:0] T_HEAD = 2'b00, T_BODY = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

  logic          clk = 1'b0;
  logic          arst;
  logic [FW-1:0] flit_i;
  logic          vc_id_i;
  logic          valid_i;
  logic [1:0]    ready_o;
  logic [1:0]    req_o;
  logic [1:0]    grant_i;
  logic          update_o;
  logic [FW-1:0] flit_o;
  logic          valid_o;
  logic          out_ready_i;
  logic          grant_err_o;
`ifdef VC_BUF_OCC_EN
  logic [2*PW-1:0] occ_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] q0 [$];
  logic [FW-1:0] q1 [$];
  logic          m_locked, m_lock, m_err;
  logic [1:0]    exp_req;
  logic          exp_valid;
  logic          exp_sel;
  logic [FW-1:0] exp_flit;

  vc_input_buffer #(.FLIT_WIDTH(FW), .BUF_DEPTH(DEPTH), .N_VC(2)) dut (
    .clk         (clk),
    .arst        (arst),
    .flit_i      (flit_i),
    .vc_id_i     (vc_id_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .req_o       (req_o),
    .grant_i     (grant_i),
    .update_o    (update_o),
    .flit_o      (flit_o),
    .valid_o     (valid_o),
    .out_ready_i (out_ready_i),
    .grant_err_o (grant_err_o)
`ifdef VC_BUF_OCC_EN
    ,
    .occ_o       (occ_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit");
  end

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [31:0] d);
    return {t, d};
  endfunction

  function automatic int qSize(input logic v);
    return v ? q1.size() : q0.size();
  endfunction

  function automatic logic [1:0] modelReq();
    logic [1:0] r;
    r[0] = (q0.size() > 0) && (!m_locked || !m_lock);
    r[1] = (q1.size() > 0) && (!m_locked || m_lock);
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Expected outputs follow from the queue contents and the packet lock alone.
  task automatic checkOutput(input string tag);
    logic [1:0] egv;
    logic       eu;
    exp_req   = modelReq();
    egv       = grant_i & exp_req;
    exp_valid = (egv == 2'b01) || (egv == 2'b10);
    exp_sel   = egv[1];
    exp_flit  = '0;
    if (exp_valid) exp_flit = exp_sel ? q1[0] : q0[0];
    eu = exp_valid && out_ready_i &&
         ((exp_flit[FW-1 -: 2] == T_TAIL) || (!m_locked && exp_flit[FW-1 -: 2] == T_HT));
    checkVal({tag, ".ready"},  64'(ready_o),     64'({q1.size() < DEPTH, q0.size() < DEPTH}));
    checkVal({tag, ".req"},    64'(req_o),       64'(exp_req));
    checkVal({tag, ".valid"},  64'(valid_o),     64'(exp_valid));
    checkVal({tag, ".flit"},   64'(flit_o),      64'(exp_flit));
    checkVal({tag, ".update"}, 64'(update_o),    64'(eu));
    checkVal({tag, ".err"},    64'(grant_err_o), 64'(m_err));
`ifdef VC_BUF_OCC_EN
    checkVal({tag, ".occ"},    64'(occ_o),       64'({3'(q1.size()), 3'(q0.size())}));
`endif
  endtask

  task automatic modelStep();
    logic       pop, push_ok;
    logic [1:0] t;
    pop     = exp_valid && out_ready_i;
    t       = exp_flit[FW-1 -: 2];
    push_ok = valid_i && (qSize(vc_id_i) < DEPTH);
    m_err   = m_err | (grant_i == 2'b11) | ((grant_i & ~exp_req) != 2'b00);
    if (pop) begin
      if (exp_sel) void'(q1.pop_front());
      else         void'(q0.pop_front());
      if (!m_locked && t == T_HEAD) begin
        m_locked = 1'b1;
        m_lock   = exp_sel;
      end else if (m_locked && t == T_TAIL) begin
        m_locked = 1'b0;
      end
    end
    if (push_ok) begin
      if (vc_id_i) q1.push_back(flit_i);
      else         q0.push_back(flit_i);
    end
  endtask

  // Drives one cycle's inputs at the falling edge; outputs stay valid for extra checks until the next rising edge.
  task automatic applyStimulus(input logic v, input logic vc, input logic [FW-1:0] f,
                               input logic [1:0] g, input logic ordy, input string tag);
    @(negedge clk);
    valid_i     = v;
    vc_id_i     = vc;
    flit_i      = f;
    grant_i     = g;
    out_ready_i = ordy;
    #1;
    checkOutput(tag);
    modelStep();
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    arst        = 1'b0;
    valid_i     = 1'b0;
    grant_i     = 2'b00;
    out_ready_i = 1'b0;
    q0.delete();
    q1.delete();
    m_locked = 1'b0;
    m_lock   = 1'b0;
    m_err    = 1'b0;
    #1;
    checkOutput(tag);
    @(negedge clk);
    arst = 1'b1;
  endtask

  initial begin
    logic [1:0] r, g;
    logic       v, vc;
    arst = 1'b0; valid_i = 1'b0; vc_id_i = 1'b0; flit_i = '0; grant_i = 2'b00; out_ready_i = 1'b0;
    m_locked = 1'b0; m_lock = 1'b0; m_err = 1'b0;
    $display("[TB] start");
    doReset("reset0");
    applyStimulus(0, 0, '0, 2'b00, 0, "idle");
    checkVal("reset.ready_const", 64'(ready_o), 64'(2'b11));

    // Single-flit packet on VC1.
    applyStimulus(1, 1, 34'h3_0000_00AA, 2'b00, 0, "sf.push");
    applyStimulus(0, 0, '0, 2'b10, 1, "sf.pop");
    checkVal("sf.flit_const", 64'(flit_o), 64'(34'h3_0000_00AA));
    checkVal("sf.update_const", 64'(update_o), 64'(1'b1));
    applyStimulus(0, 0, '0, 2'b00, 0, "sf.after");
    checkVal("sf.req_const", 64'(req_o), 64'(2'b00));

    // Packet lock with an illegal grant mid-packet.
    applyStimulus(1, 0, mk(T_HEAD, 32'h11), 2'b00, 0, "lk.push_h");
    applyStimulus(1, 0, mk(T_BODY, 32'h12), 2'b00, 0, "lk.push_b");
    applyStimulus(1, 0, mk(T_TAIL, 32'h13), 2'b00, 0, "lk.push_t");
    applyStimulus(1, 1, mk(T_HT,   32'h14), 2'b00, 0, "lk.push_ht");
    applyStimulus(0, 0, '0, 2'b01, 1, "lk.pop_h");
    applyStimulus(0, 0, '0, 2'b10, 1, "lk.bad_grant");
    checkVal("lk.req_const", 64'(req_o), 64'(2'b01));
    checkVal("lk.valid_const", 64'(valid_o), 64'(1'b0));
    applyStimulus(0, 0, '0, 2'b00, 1, "lk.err");
    checkVal("lk.err_const", 64'(grant_err_o), 64'(1'b1));
    applyStimulus(0, 0, '0, 2'b01, 1, "lk.pop_b");
    applyStimulus(0, 0, '0, 2'b01, 1, "lk.pop_t");
    checkVal("lk.update_const", 64'(update_o), 64'(1'b1));
    applyStimulus(0, 0, '0, 2'b00, 0, "lk.released");
    checkVal("lk.req_after_const", 64'(req_o), 64'(2'b10));
    applyStimulus(0, 0, '0, 2'b10, 1, "lk.pop_ht");

    // Reset mid-packet discards queued flits and the lock.
    applyStimulus(1, 0, mk(T_HEAD, 32'h21), 2'b00, 0, "rs.push_h");
    applyStimulus(1, 1, mk(T_HT,   32'h22), 2'b00, 0, "rs.push_ht");
    applyStimulus(1, 0, mk(T_BODY, 32'h23), 2'b01, 1, "rs.pop_h");
    doReset("rs.reset");
    applyStimulus(0, 0, '0, 2'b00, 0, "rs.after");
    checkVal("rs.req_const", 64'(req_o), 64'(2'b00));
    checkVal("rs.err_const", 64'(grant_err_o), 64'(1'b0));

    // Fill VC0, free one slot, then stream push+pop across the pointer wrap.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, mk(T_BODY, 32'h100 + i), 2'b00, 0, "fw.fill");
    applyStimulus(0, 0, '0, 2'b00, 0, "fw.full");
    checkVal("fw.full_const", 64'(ready_o[0]), 64'(1'b0));
    applyStimulus(0, 0, '0, 2'b01, 1, "fw.net_pop");
    applyStimulus(0, 0, '0, 2'b00, 0, "fw.not_full");
    checkVal("fw.ready_const", 64'(ready_o[0]), 64'(1'b1));
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, mk(T_BODY, 32'h200 + i), 2'b01, 1, "fw.stream");
    while (q0.size() > 0) applyStimulus(0, 0, '0, 2'b01, 1, "fw.drain");

    // Backpressure: grant held while downstream stalls.
    applyStimulus(1, 0, mk(T_HEAD, 32'h300), 2'b00, 0, "bp.push_h");
    applyStimulus(1, 0, mk(T_TAIL, 32'h301), 2'b00, 0, "bp.push_t");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, '0, 2'b01, 0, "bp.stall");
      checkVal("bp.flit_const", 64'(flit_o), 64'(mk(T_HEAD, 32'h300)));
    end
    applyStimulus(0, 0, '0, 2'b01, 1, "bp.pop_h");
    applyStimulus(0, 0, '0, 2'b01, 1, "bp.pop_t");
    checkVal("bp.update_const", 64'(update_o), 64'(1'b1));

    // Occupancy scenario.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, mk(T_BODY, 32'h400 + i), 2'b00, 0, "oc.push0");
    applyStimulus(1, 1, mk(T_BODY, 32'h410), 2'b00, 0, "oc.push1");
    applyStimulus(0, 0, '0, 2'b00, 0, "oc.hold");
`ifdef VC_BUF_OCC_EN
    checkVal("oc.occ_const", 64'(occ_o), 64'({3'd1, 3'd3}));
`endif
    applyStimulus(0, 0, '0, 2'b01, 1, "oc.pop0");
    applyStimulus(0, 0, '0, 2'b00, 0, "oc.hold2");
`ifdef VC_BUF_OCC_EN
    checkVal("oc.occ2_const", 64'(occ_o), 64'({3'd1, 3'd2}));
`endif
    while (q0.size() > 0) applyStimulus(0, 0, '0, 2'b01, 1, "oc.drain0");
    applyStimulus(0, 0, '0, 2'b10, 1, "oc.drain1");

    // Random legal traffic with random flit types, including out-of-place ones.
    for (int n = 0; n < 500; n++) begin
      r = modelReq();
      g = 2'b00;
      if (r != 2'b00 && $urandom_range(0, 3) != 0) begin
        if (r == 2'b11) g = $urandom_range(0, 1) ? 2'b10 : 2'b01;
        else            g = r;
      end
      vc = 1'($urandom_range(0, 1));
      v  = 1'($urandom_range(0, 1));
      if (qSize(vc) >= DEPTH) v = 1'b0;
      applyStimulus(v, vc, mk(2'($urandom_range(0, 3)), $urandom), g,
                    1'($urandom_range(0, 3) != 0), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
